// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF-stage PC generator and fetch aligner for the MIPS-32 pipeline
//
// Purpose:
//   Generates the word address for a synchronous instruction memory (data is
//   registered on posedge from imem_pc) and presents each fetched instruction to
//   decode together with its PC, PC+1 and a valid bit. Handles hazard stalls,
//   taken branch/jump redirects and a sticky out-of-range fetch fault. The word
//   on decode is captured locally during a stall because the memory re-reads
//   every edge.
//
// Ports:
//   clk          in   1     rising-edge clock shared with the instruction memory
//   rst_n        in   1     asynchronous, active-low reset
//   stall        in   1     hold PC and the decode-facing outputs
//   redirect     in   1     taken branch/jump; priority over stall
//   redirect_pc  in   PC_W  word target for redirect
//   imem_pc      out  PC_W  address to instruction memory (= pc_q)
//   imem_inst    in   32    instruction memory read data
//   id_inst      out  32    instruction to decode
//   id_pc        out  PC_W  word PC of id_inst
//   id_pc_plus1  out  PC_W  id_pc + 1 (mod 2^PC_W)
//   id_valid     out  1     id_inst/id_pc are valid
//   fetch_fault  out  1     sticky: fetch attempted at PC >= MEM_DEPTH

`timescale 1ns/1ps

module fetch_unit #(
    parameter int unsigned       PC_W      = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter int unsigned       MEM_DEPTH = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_inst,
    output logic [31:0]     id_inst,
    output logic [PC_W-1:0] id_pc,
    output logic [PC_W-1:0] id_pc_plus1,
    output logic            id_valid,
    output logic            fetch_fault
);

    // Depth extended by one bit so the range compare is exact for any PC_W.
    localparam logic [PC_W:0]   DEPTH_EXT = (PC_W+1)'(MEM_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

    logic [PC_W-1:0] pc_q,          pc_d;
    logic [PC_W-1:0] fet_pc_q,      fet_pc_d;
    logic [PC_W-1:0] fet_pc_p1_q,   fet_pc_p1_d;
    logic            fet_vld_q,     fet_vld_d;
    logic [31:0]     hold_inst_q,   hold_inst_d;
    logic            hold_vld_q,    hold_vld_d;
    logic            fault_q,       fault_d;

    logic            pc_out_of_range;
    logic [PC_W-1:0] pc_plus1;

    assign pc_out_of_range = ({1'b0, pc_q} >= DEPTH_EXT);
    assign pc_plus1        = pc_q + PC_ONE;

    always_comb begin
        pc_d        = pc_q;
        fet_pc_d    = fet_pc_q;
        fet_pc_p1_d = fet_pc_p1_q;
        fet_vld_d   = fet_vld_q;
        hold_inst_d = hold_inst_q;
        hold_vld_d  = hold_vld_q;
        fault_d     = fault_q;

        if (redirect) begin
            // The word the memory latches on this edge is wrong-path: squash it.
            pc_d       = redirect_pc;
            fet_vld_d  = 1'b0;
            hold_vld_d = 1'b0;
        end else if (fault_q) begin
            fet_vld_d  = 1'b0;
        end else if (stall) begin
            // Capture the word on decode before the memory overwrites it with
            // mem[pc_q]; later stall cycles keep the first capture.
            if (!hold_vld_q) begin
                hold_inst_d = imem_inst;
                hold_vld_d  = 1'b1;
            end
        end else if (pc_out_of_range) begin
            fault_d    = 1'b1;
            fet_vld_d  = 1'b0;
        end else begin
            fet_pc_d    = pc_q;
            fet_pc_p1_d = pc_plus1;
            fet_vld_d   = 1'b1;
            pc_d        = pc_plus1;
            hold_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fet_pc_q    <= '0;
            fet_pc_p1_q <= PC_ONE;
            fet_vld_q   <= 1'b0;
            hold_inst_q <= '0;
            hold_vld_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fet_pc_q    <= fet_pc_d;
            fet_pc_p1_q <= fet_pc_p1_d;
            fet_vld_q   <= fet_vld_d;
            hold_inst_q <= hold_inst_d;
            hold_vld_q  <= hold_vld_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_pc     = pc_q;
    assign id_inst     = hold_vld_q ? hold_inst_q : imem_inst;
    assign id_pc       = fet_pc_q;
    assign id_pc_plus1 = fet_pc_p1_q;
    assign id_valid    = fet_vld_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a transaction-level fetch model

`timescale 1ns/1ps

module tb_fetch_unit;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus1;
    logic        id_valid;
    logic        fetch_fault;

    fetch_unit #(.PC_W(32), .RESET_PC(32'd0), .MEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_inst   (imem_inst),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .id_valid    (id_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:DEPTH-1];

    always @(posedge clk)
        imem_inst <= (imem_pc < DEPTH) ? mem[imem_pc[6:0]] : 32'hdeadbeef;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          fault;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Model: what decode is showing, the next address to fetch, and the fault flag.
    bit          m_v;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_next;
    bit          m_fault;

    task automatic model_reset();
        m_v     = 1'b0;
        m_pc    = 32'd0;
        m_inst  = 32'd0;
        m_next  = 32'd0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit r, input logic [31:0] t);
        exp_t e;
        if (r) begin
            m_next = t;
            m_v    = 1'b0;
        end else if (m_fault) begin
            m_v = 1'b0;
        end else if (s) begin
            // decode keeps showing the same instruction (or the same bubble)
        end else if (m_next >= DEPTH) begin
            m_fault = 1'b1;
            m_v     = 1'b0;
        end else begin
            m_v    = 1'b1;
            m_pc   = m_next;
            m_inst = mem[m_next[6:0]];
            m_next = m_next + 32'd1;
        end
        e.v     = m_v;
        e.pc    = m_pc;
        e.inst  = m_inst;
        e.fault = m_fault;
        e.npc   = m_next;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] t);
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        model_edge(s, r, t);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        n_vec++;
        if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_pc_plus1 !== 32'd1 ||
            fetch_fault !== 1'b0 || imem_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: valid=%b pc=%h pc1=%h fault=%b imem_pc=%h, want 0 0 1 0 0",
                     tag, id_valid, id_pc, id_pc_plus1, fetch_fault, imem_pc);
        end
    endtask

    task automatic pulse_reset(input string tag);
        stall    = 1'b0;
        redirect = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset(tag);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one expectation per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (id_valid !== e.v) begin
                    n_fail++;
                    $display("FAIL id_valid: got %b want %b (t=%0t)", id_valid, e.v, $time);
                end else if (e.v && (id_pc !== e.pc || id_inst !== e.inst ||
                                     id_pc_plus1 !== e.pc + 32'd1)) begin
                    n_fail++;
                    $display("FAIL id_data: got pc=%h inst=%h pc1=%h want pc=%h inst=%h pc1=%h (t=%0t)",
                             id_pc, id_inst, id_pc_plus1, e.pc, e.inst, e.pc + 32'd1, $time);
                end
                if (fetch_fault !== e.fault || imem_pc !== e.npc) begin
                    n_fail++;
                    $display("FAIL fault_pc: got fault=%b imem_pc=%h want fault=%b imem_pc=%h (t=%0t)",
                             fetch_fault, imem_pc, e.fault, e.npc, $time);
                end
            end
        end
    end

    initial begin
        bit          s;
        bit          r;
        logic [31:0] t;
        int unsigned rr;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h8c070003;
        mem[1] = 32'h8c030009;
        mem[2] = 32'h8c060006;
        mem[3] = 32'h00672822;
        mem[4] = 32'h10a70000;

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        model_reset();

        @(negedge clk);
        #1;
        check_reset("reset_state");
        rst_n = 1'b1;

        // T1/T2: run, stall 3 cycles on pc 1, run on
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // T3: redirect to 0 while pc 3 shown
        step(0, 1, 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        // T4: stall and redirect together
        step(1, 1, 32'd2);
        step(0, 0, 0);
        step(0, 0, 0);
        // T5: run off the end of memory, then try to recover without reset
        step(0, 1, 32'd126);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 32'd5);
        step(0, 0, 0);
        step(0, 0, 0);
        // T6: reset mid-stall, then restart at 0
        pulse_reset("fault_reset");
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        pulse_reset("stall_reset");
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 2) begin
                pulse_reset("rand_reset");
            end else begin
                s = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 1) == 0) t = $urandom_range(110, 131);
                else                           t = $urandom_range(0, 127);
                step(s, r, t);
            end
        end

        stall    = 1'b0;
        redirect = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
